// File: rtl/alu_bist_ctrl_if.sv
// ALU port bundle between the BIST sequencer (master) and the ALU (slave).
interface alu_bist_ctrl_if #(
   parameter int B_W = 8
);
   logic [3:0]     opcode;
   logic [B_W-1:0] a;
   logic [B_W-1:0] b;
   logic           c_in;
   logic [B_W-1:0] y;
   logic           c_out;
   logic           borrow;
   logic           zero;
   logic           parity;
   logic           invalid_op;

   modport master (
      output opcode, a, b, c_in,
      input  y, c_out, borrow, zero, parity, invalid_op
   );

   modport slave (
      input  opcode, a, b, c_in,
      output y, c_out, borrow, zero, parity, invalid_op
   );
endinterface

// File: rtl/alu_bist_ctrl.sv
// ALU self-test sequencer: LFSR vector generation, MISR response compaction,
// invalid-opcode counting and golden-signature compare.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | after reset, nothing running, alu_* outputs forced to 0
// RUN   | one LFSR vector applied and one ALU response captured per clock
// DONE  | results held, alu_* outputs forced to 0; start re-runs
module alu_bist_ctrl #(
   parameter int          B_W   = 8,
   parameter int          N_VEC = 100,
   parameter logic [31:0] SEED  = 32'h0001_2345,
   parameter int          SIG_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [SIG_W-1:0] golden_sig,
   alu_bist_ctrl_if.master  alu,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [SIG_W-1:0] signature,
   output logic [15:0]      vec_count,
   output logic [15:0]      invalid_count
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // An all-zero seed would lock the LFSR, so it is replaced by 1.
   localparam logic [31:0]      SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
   localparam logic [SIG_W-1:0] POLY     = SIG_W'(17'h0_1021);
   localparam logic [15:0]      LAST_VEC = 16'(N_VEC - 1);

   state_t           state;
   logic [31:0]      lfsr;
   logic [31:0]      lfsr_next;
   logic [SIG_W-1:0] resp_word;
   logic [SIG_W-1:0] misr_next;

   // Next LFSR value and MISR update from the current ALU response.
   always_comb begin
      lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
      resp_word = SIG_W'({alu.invalid_op, alu.parity, alu.zero,
                          alu.borrow, alu.c_out, alu.y});
      misr_next = {signature[SIG_W-2:0], 1'b0}
                ^ (signature[SIG_W-1] ? POLY : '0)
                ^ resp_word;
   end

   // Vector decode; gated by busy so the ALU sees zeros outside RUN.
   always_comb begin
      alu.opcode = busy ? lfsr[3:0]           : 4'h0;
      alu.a      = busy ? lfsr[4 +: B_W]      : '0;
      alu.b      = busy ? lfsr[4+B_W +: B_W]  : '0;
      alu.c_in   = busy ? lfsr[4+2*B_W]       : 1'b0;
   end

   assign pass = done & (signature == golden_sig);

   // Sequencer FSM with registered busy/done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_IDLE;
         lfsr          <= '0;
         signature     <= '0;
         vec_count     <= '0;
         invalid_count <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state         <= ST_RUN;
                  lfsr          <= SEED_EFF;
                  signature     <= '0;
                  vec_count     <= '0;
                  invalid_count <= '0;
                  busy          <= 1'b1;
                  done          <= 1'b0;
               end
            end
            ST_RUN: begin
               signature <= misr_next;
               lfsr      <= lfsr_next;
               vec_count <= vec_count + 16'd1;
               if (alu.invalid_op && (invalid_count != 16'hFFFF))
                  invalid_count <= invalid_count + 16'd1;
               if (vec_count == LAST_VEC) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule
